// File: rtl/stream_credit_tx.sv
// Credit-based stream transmitter: forwards valid/ready beats onto a link with no
// backpressure, sending only while it holds credits for free receiver slots.
module stream_credit_tx #(
  parameter int  DATA_WIDTH  = 32,
  parameter type T           = logic [DATA_WIDTH-1:0],
  parameter int  CREDITS     = 8,
  parameter int  LINK_STAGES = 0,
  parameter int  CNT_WIDTH   = $clog2(CREDITS+1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  T                     data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output T                     data_o,
  output logic                 valid_o,
  input  logic                 credit_i,
  output logic [CNT_WIDTH-1:0] credits_o,
  output logic                 idle_o,
  output logic                 err_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(CREDITS);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 send, overflow, pipe_busy;

  // ready never looks at valid_i, so upstream may wait on ready safely
  assign ready_o  = (cnt_q != '0) && !flush_i;
  assign send     = valid_i && ready_o;
  assign overflow = credit_i && !send && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (overflow)               err_d = 1'b1;
    else if (send && !credit_i) cnt_d = cnt_q - CNT_ONE;
    else if (credit_i && !send) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= CNT_MAX;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  if (LINK_STAGES == 0) begin : g_comb
    assign valid_o   = send;
    assign data_o    = data_i;
    assign pipe_busy = 1'b0;
  end else begin : g_pipe
    logic [LINK_STAGES-1:0] vld_q, vld_d;
    T                       data_q [LINK_STAGES];
    T                       data_d [LINK_STAGES];

    always_comb begin
      vld_d     = '0;
      vld_d[0]  = send;
      data_d[0] = data_i;
      for (int k = 1; k < LINK_STAGES; k++) begin
        vld_d[k]  = vld_q[k-1];
        data_d[k] = data_q[k-1];
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) vld_q <= '0;
      else       vld_q <= vld_d;
    end

    // payload needs no reset; the valid bits qualify it
    always_ff @(posedge clk_i) begin
      data_q <= data_d;
    end

    assign valid_o   = vld_q[LINK_STAGES-1];
    assign data_o    = data_q[LINK_STAGES-1];
    assign pipe_busy = |vld_q;
  end

  assign credits_o = cnt_q;
  assign idle_o    = (cnt_q == CNT_MAX) && !pipe_busy;
  assign err_o     = err_q;

endmodule

// File: tb/tb_stream_credit_tx.sv
// Bench for stream_credit_tx (CREDITS=4, LINK_STAGES=2): directed scenarios then
// random traffic, checked against a timestamped send-log reference model.
module tb_stream_credit_tx;
  localparam int CREDITS = 4;
  localparam int LS      = 2;
  localparam int DW      = 32;
  localparam int CW      = $clog2(CREDITS+1);

  logic          clk = 1'b0;
  logic          rst, flush, valid, credit;
  logic [DW-1:0] din, dout;
  logic          ready, vout, idle, err;
  logic [CW-1:0] credits;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_credit_tx #(
    .DATA_WIDTH(DW), .CREDITS(CREDITS), .LINK_STAGES(LS)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(din), .valid_i(valid),
    .ready_o(ready), .data_o(dout), .valid_o(vout), .credit_i(credit),
    .credits_o(credits), .idle_o(idle), .err_o(err)
  );

  // reference: credit count, sticky error, and a log of sends keyed by cycle;
  // a beat sent in cycle c must show on the link in cycle c+LS
  int            cnt_m;
  bit            err_m;
  int            cyc;
  int            rx_cnt;
  logic [31:0]   sd[int];

  function automatic bit m_ready();
    return (cnt_m != 0) && !flush;
  endfunction

  function automatic bit m_busy();
    for (int k = 1; k <= LS; k++)
      if (sd.exists(cyc - k)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit snd;
    @(negedge clk);
    chk("ready_o", ready, m_ready());
    chk("credits_o", credits, cnt_m);
    chk("valid_o", vout, sd.exists(cyc - LS));
    if (sd.exists(cyc - LS)) chk("data_o", dout, sd[cyc - LS]);
    chk("idle_o", idle, (cnt_m == CREDITS) && !m_busy());
    chk("err_o", err, err_m);
    if (vout === 1'b1) rx_cnt++;
    @(posedge clk);
    if (rst) begin
      cnt_m = CREDITS;
      err_m = 1'b0;
      sd.delete();
    end else begin
      snd = valid && m_ready();
      if (snd) sd[cyc] = din;
      if (credit && !snd && cnt_m == CREDITS) err_m = 1'b1;
      else cnt_m = cnt_m - int'(snd) + int'(credit);
    end
    cyc++;
    #1;
  endtask

  int rx0;

  initial begin
    rst = 1'b1; flush = 1'b0; valid = 1'b0; credit = 1'b0; din = '0;
    cyc = 0; rx_cnt = 0;
    @(posedge clk); #1;
    cnt_m = CREDITS; err_m = 1'b0;
    step();  // reset cycle held once more, checked
    rst = 1'b0;

    // 1: stream 1,2,3,... with no credits back: only CREDITS beats go out
    rx0 = rx_cnt;
    valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      din = i;
      step();
    end
    chk("s1_beats", rx_cnt - rx0, 4);
    chk("s1_empty", credits, 0);

    // 2: one credit back from empty
    credit = 1'b1; din = 32'h55;
    step();
    chk("s2_cred1", credits, 1);
    chk("s2_ready1", ready, 1);
    credit = 1'b0;
    step();
    chk("s2_cred0", credits, 0);
    chk("s2_ready0", ready, 0);

    // 3: steady state at cnt==2, send and credit every cycle
    valid = 1'b0; credit = 1'b1;
    repeat (2) step();
    rx0 = rx_cnt;
    valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din = 32'h100 + i;
      step();
      chk("s3_cred", credits, 2);
    end
    valid = 1'b0; credit = 1'b0;
    repeat (3) step();
    chk("s3_beats", rx_cnt - rx0, 10);
    credit = 1'b1;
    repeat (2) step();

    // 4: overflow at full credits
    step();
    credit = 1'b0;
    chk("s4_sat", credits, 4);
    chk("s4_err", err, 1);
    flush = 1'b1; step();
    flush = 1'b0; step();
    chk("s4_err_flush", err, 1);
    rst = 1'b1; step();
    rst = 1'b0;
    chk("s4_err_rst", err, 0);

    // 5: flush holds off new sends while in-flight beats drain
    valid = 1'b1; din = 32'hA1; step();
    din = 32'hA2; step();
    rx0 = rx_cnt;
    flush = 1'b1; din = 32'hBAD;
    repeat (4) step();
    chk("s5_ready", ready, 0);
    chk("s5_cred", credits, 2);
    chk("s5_drain", rx_cnt - rx0, 2);
    credit = 1'b1;
    repeat (2) step();
    credit = 1'b0;
    chk("s5_idle", idle, 1);
    flush = 1'b0; valid = 1'b0;

    // 6: reset with beats in flight
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 32'hC0 + i;
      step();
    end
    valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s6_valid", vout, 0);
    chk("s6_cred", credits, 4);
    chk("s6_idle", idle, 1);
    chk("s6_err", err, 0);

    // random traffic; credits returned only for outstanding slots
    for (int i = 0; i < 400; i++) begin
      valid  = ($urandom_range(0, 3) != 0);
      flush  = ($urandom_range(0, 7) == 0);
      credit = (cnt_m < CREDITS) && ($urandom_range(0, 2) != 0);
      rst    = ($urandom_range(0, 99) == 0);
      din    = $urandom;
      step();
    end
    rst = 1'b0; valid = 1'b0; flush = 1'b0; credit = 1'b0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
